// File: rtl/seg_scan_driver.sv
// Double-buffered 8-tube 7-segment scanner: accepts whole frames over valid/ready
// and time-multiplexes them onto digit1 (tubes 7..4) and digit2 (tubes 3..0).
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [31:0] digits_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blink_in,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic               pending_full;
  logic [31:0]        pend_digits;
  logic [7:0]         pend_blank;
  logic [7:0]         pend_dp;
  logic [7:0]         pend_blink;

  logic [31:0]        act_digits;
  logic [7:0]         act_blank;
  logic [7:0]         act_dp;
  logic [7:0]         act_blink;

  logic               accept;
  logic               scan_tick;
  logic               frame_wrap;
  logic               transfer;
  logic [7:0]         pattern;

  assign frame_ready = ~pending_full;
  assign accept      = frame_valid & ~pending_full;
  assign scan_tick   = enable & (scan_cnt == SCAN_LAST);
  assign frame_wrap  = scan_tick & (scan_idx == 3'd7);
  // Swapping only at the wrap keeps a whole scan pass on one frame; while
  // the display is off there is nothing to tear, so the swap is immediate.
  assign transfer    = pending_full & (frame_wrap | ~enable);

  always_comb begin
    pattern = hex_seg(act_digits[{scan_idx, 2'b00} +: 4]) | {7'b0, act_dp[scan_idx]};
    if (act_blank[scan_idx] || (act_blink[scan_idx] && blink_phase))
      pattern = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      scan_cnt <= '0;
      scan_idx <= 3'd0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_full <= 1'b0;
      pend_digits  <= '0;
      pend_blank   <= '0;
      pend_dp      <= '0;
      pend_blink   <= '0;
      act_digits   <= '0;
      act_blank    <= 8'hFF;
      act_dp       <= '0;
      act_blink    <= '0;
    end else begin
      if (transfer) begin
        act_digits <= pend_digits;
        act_blank  <= pend_blank;
        act_dp     <= pend_dp;
        act_blink  <= pend_blink;
      end
      if (accept) begin
        pend_digits  <= digits_in;
        pend_blank   <= blank_in;
        pend_dp      <= dp_in;
        pend_blink   <= blink_in;
        pending_full <= 1'b1;
      end else if (transfer) begin
        pending_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      digit1   <= 8'h00;
      digit2   <= 8'h00;
      tube_sel <= 8'h00;
    end else begin
      tube_sel <= 8'h01 << scan_idx;
      if (scan_idx[2]) begin
        digit1 <= pattern;
        digit2 <= 8'h00;
      end else begin
        digit1 <= 8'h00;
        digit2 <= pattern;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a cycle-count based reference
// model of the scan position, blink phase and frame double buffer.
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;
  localparam int PASS      = 8 * SCAN_DIV;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  dp;
    logic [7:0]  bl;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [31:0] digits_in = '0;
  logic [7:0]  blank_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blink_in = '0;
  logic [7:0]  digit1;
  logic [7:0]  digit2;
  logic [7:0]  tube_sel;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .digits_in(digits_in), .blank_in(blank_in), .dp_in(dp_in), .blink_in(blink_in),
    .digit1(digit1), .digit2(digit2), .tube_sel(tube_sel)
  );

  logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  logic       model_ok = 1'b0;
  frame_t     act;
  frame_t     pend_q[$];
  int         en_run = 0;
  int         blink_n = 0;
  logic [7:0] exp_d1 = '0;
  logic [7:0] exp_d2 = '0;
  logic [7:0] exp_sel = '0;
  logic       offering = 1'b0;
  frame_t     cur;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%02h expected=%02h", tag, cycle, got, exp);
    end
  endtask

  // Advances the model across one clock edge using the inputs driven for it.
  task automatic modelEdge(input logic r, input logic e, input logic v, input frame_t f);
    int s;
    int nib;
    logic [7:0] seg;
    logic boundary;
    logic acc;
    if (r) begin
      exp_d1 = 8'h00; exp_d2 = 8'h00; exp_sel = 8'h00;
      pend_q.delete();
      act.d = '0; act.b = 8'hFF; act.dp = '0; act.bl = '0;
      en_run = 0; blink_n = 0; model_ok = 1'b1;
      return;
    end
    if (!e) begin
      exp_d1 = 8'h00; exp_d2 = 8'h00; exp_sel = 8'h00;
    end else begin
      s = (en_run / SCAN_DIV) % 8;
      nib = int'((act.d >> (4 * s)) & 32'hF);
      seg = hex_tab[nib];
      if (act.dp[s]) seg = seg | 8'h01;
      if (act.b[s] || (act.bl[s] && ((blink_n / BLINK_DIV) % 2 == 1))) seg = 8'h00;
      exp_sel = 8'(1 << s);
      exp_d1 = (s >= 4) ? seg : 8'h00;
      exp_d2 = (s >= 4) ? 8'h00 : seg;
    end
    boundary = e && ((en_run % PASS) == PASS - 1);
    acc = v && (pend_q.size() == 0);
    if (pend_q.size() != 0 && (!e || boundary)) act = pend_q.pop_front();
    if (acc) pend_q.push_back(f);
    en_run = e ? en_run + 1 : 0;
    blink_n++;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v, input frame_t f);
    @(negedge clk);
    cycle++;
    if (model_ok) begin
      checkOutput("digit1", digit1, exp_d1);
      checkOutput("digit2", digit2, exp_d2);
      checkOutput("tube_sel", tube_sel, exp_sel);
      checkOutput("frame_ready", {7'b0, frame_ready}, {7'b0, pend_q.size() == 0});
    end
    rst = r; enable = e; frame_valid = v;
    digits_in = f.d; blank_in = f.b; dp_in = f.dp; blink_in = f.bl;
    modelEdge(r, e, v, f);
  endtask

  // A frame on offer is held until the model sees it accepted.
  task automatic driveCycle(input logic r, input logic e);
    logic rdy;
    rdy = (pend_q.size() == 0);
    applyStimulus(r, e, offering, cur);
    if (!r && offering && rdy) offering = 1'b0;
  endtask

  initial begin
    logic en;
    cur = '0;
    repeat (3) driveCycle(1'b1, 1'b1);

    cur.d = 32'h76543210; cur.b = 8'h00; cur.dp = 8'h00; cur.bl = 8'h00;
    offering = 1'b1;
    repeat (3 * PASS) driveCycle(1'b0, 1'b1);

    cur.d = 32'hFFFFFFFF; cur.b = 8'h80; cur.dp = 8'h10; cur.bl = 8'h01;
    offering = 1'b1;
    repeat (3 * PASS) driveCycle(1'b0, 1'b1);

    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (!offering && $urandom_range(0, 9) == 0) begin
        cur.d  = $urandom;
        cur.b  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        cur.dp = 8'($urandom);
        cur.bl = 8'($urandom) & 8'($urandom);
        offering = 1'b1;
      end
      if ($urandom_range(0, 79) == 0) en = ~en;
      driveCycle($urandom_range(0, 299) == 0, en);
    end
    driveCycle(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
